// File: rtl/counter_step_scheduler.sv
// Round-robin step scheduler for the four-digit signed counter: grants one of two
// requesters, paces its steps every TICK_DIV cycles and sequences counter clears.
module counter_step_scheduler #(
    parameter int RW       = 8,
    parameter int TICK_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          mode0,
    input  logic [3:0]    val0,
    input  logic [RW-1:0] rpt0,
    output logic          ack0,
    output logic          done0,
    input  logic          req1,
    input  logic          mode1,
    input  logic [3:0]    val1,
    input  logic [RW-1:0] rpt1,
    output logic          ack1,
    output logic          done1,
    input  logic          clr_req,
    output logic          cnt_clr_n,
    output logic          step_en,
    output logic          step_mode,
    output logic [3:0]    step_value,
    output logic          busy,
    output logic          grant
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t        state;
    logic          ptr;
    logic          clr_pend;
    logic [TW-1:0] tick;
    logic [RW-1:0] remaining;
    logic          any_req;
    logic          pick;

    always_comb begin
        any_req = req0 | req1;
        pick    = (req0 & req1) ? ptr : req1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            clr_pend   <= 1'b0;
            tick       <= '0;
            remaining  <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            cnt_clr_n  <= 1'b1;
            step_en    <= 1'b0;
            step_mode  <= 1'b0;
            step_value <= '0;
            busy       <= 1'b0;
            grant      <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            step_en   <= 1'b0;
            cnt_clr_n <= 1'b1;
            if (clr_req)
                clr_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (clr_pend || clr_req) begin
                        cnt_clr_n <= 1'b0;
                        clr_pend  <= 1'b0;
                        state     <= CLEAR;
                    end else if (any_req) begin
                        grant      <= pick;
                        ptr        <= ~pick;
                        ack0       <= ~pick;
                        ack1       <= pick;
                        busy       <= 1'b1;
                        step_mode  <= pick ? mode1 : mode0;
                        step_value <= pick ? val1 : val0;
                        remaining  <= pick ? rpt1 : rpt0;
                        tick       <= '0;
                        state      <= RUN;
                    end
                end
                CLEAR: state <= IDLE;
                RUN: begin
                    // RUN with nothing left raises done, so DONE is the cycle the pulse is visible
                    if (remaining == '0) begin
                        done0 <= ~grant;
                        done1 <= grant;
                        state <= DONE;
                    end else if (tick == TICK_LAST) begin
                        step_en   <= 1'b1;
                        tick      <= '0;
                        remaining <= remaining - RW'(1);
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_step_scheduler.sv
// Self-checking bench for counter_step_scheduler: timeline model per command plus
// an attached counter fed by step_en.
module tb_counter_step_scheduler;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, mode0 = 1'b0, req1 = 1'b0, mode1 = 1'b0;
    logic [3:0] val0 = '0, val1 = '0;
    logic [7:0] rpt0 = '0, rpt1 = '0;
    logic       clr_req = 1'b0;
    logic       ack0, done0, ack1, done1, cnt_clr_n, step_en, step_mode, busy, grant;
    logic [3:0] step_value;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cnt_obs = 0;
    int mptr = 0;

    counter_step_scheduler #(.RW(8), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .mode0(mode0), .val0(val0), .rpt0(rpt0), .ack0(ack0), .done0(done0),
        .req1(req1), .mode1(mode1), .val1(val1), .rpt1(rpt1), .ack1(ack1), .done1(done1),
        .clr_req(clr_req), .cnt_clr_n(cnt_clr_n), .step_en(step_en), .step_mode(step_mode),
        .step_value(step_value), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // attached signed counter driven only by the DUT's step/clear outputs
    always @(posedge clk) begin
        if (!cnt_clr_n)
            cnt_obs <= 0;
        else if (step_en)
            cnt_obs <= step_mode ? cnt_obs - int'(step_value) : cnt_obs + int'(step_value);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; clr_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mptr = 0;
        @(negedge clk);
    endtask

    // Waits for an ack, then checks every cycle up to one past the predicted done.
    task automatic expect_cmd(input string tag, input int who, input int m, input int v,
                              input int r, input int exp_ack, input bit drop,
                              input bit arm_clr, output int done_c);
        int a, dc;
        bit found, stepx;
        logic [8:0] g9, e9;
        logic [6:0] g7, e7;
        found = 0;
        done_c = cyc;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (ack0 || ack1) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s ack_timeout: got no ack, want ack%0d", tag, who);
            return;
        end
        a = cyc;
        g9 = {ack1, ack0, grant, busy, step_mode, step_value};
        e9 = {who == 1, who == 0, 1'(who), 1'b1, 1'(m), 4'(v)};
        if (g9 !== e9) begin
            bad++;
            $display("FAIL %s ack_state: got %b want %b", tag, g9, e9);
        end
        if (exp_ack >= 0) begin
            total++;
            if (a !== exp_ack) begin
                bad++;
                $display("FAIL %s ack_cycle: got %0d want %0d", tag, a, exp_ack);
            end
        end
        if (drop) begin
            if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        dc = a + r * TD + 1;
        for (int c = a + 1; c <= dc; c++) begin
            @(negedge clk);
            if (arm_clr && c == a + 1) begin clr_req = 1'b1; req1 = 1'b1; end
            if (arm_clr && c == a + 2) clr_req = 1'b0;
            stepx = ((c - a) % TD == 0) && ((c - a) <= r * TD);
            g7 = {step_en, done1, done0, busy, ack1, ack0, cnt_clr_n};
            e7 = {stepx, c == dc && who == 1, c == dc && who == 0, 1'b1, 1'b0, 1'b0, 1'b1};
            total++;
            if (g7 !== e7) begin
                bad++;
                $display("FAIL %s run_c%0d: got %b want %b", tag, c - a, g7, e7);
            end
            if (stepx) begin
                total++;
                if ({step_mode, step_value} !== {1'(m), 4'(v)}) begin
                    bad++;
                    $display("FAIL %s step_payload: got %b want %b", tag,
                             {step_mode, step_value}, {1'(m), 4'(v)});
                end
            end
        end
        @(negedge clk);
        total++;
        if ({busy, done0, done1, step_en} !== 4'b0000) begin
            bad++;
            $display("FAIL %s post_done: got %b want 0000", tag, {busy, done0, done1, step_en});
        end
        done_c = dc;
    endtask

    task automatic check_reset_values(input string tag);
        logic [13:0] g;
        g = {ack0, ack1, done0, done1, step_en, step_mode, step_value, busy, grant, cnt_clr_n};
        total++;
        if (g !== 14'b00000_0_0000_001) begin
            bad++;
            $display("FAIL %s reset_values: got %b want %b", tag, g, 14'b00000000000001);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        check_reset_values("reset_hold");
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int base, c0, dc;
        base = cnt_obs;
        mode0 = 1'b0; val0 = 4'd3; rpt0 = 8'd3; req0 = 1'b1;
        c0 = cyc;
        expect_cmd("single", 0, 0, 3, 3, c0 + 1, 1, 0, dc);
        total++;
        if (cnt_obs - base !== 9) begin
            bad++;
            $display("FAIL single_count: got %0d want 9", cnt_obs - base);
        end
    endtask

    task automatic test_round_robin();
        int dc;
        do_reset();
        mode0 = 1'b0; val0 = 4'd1; rpt0 = 8'd1;
        mode1 = 1'b1; val1 = 4'd2; rpt1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        expect_cmd("rr0", 0, 0, 1, 1, cyc + 1, 0, 0, dc);
        expect_cmd("rr1", 1, 1, 2, 1, dc + 2, 0, 0, dc);
        expect_cmd("rr2", 0, 0, 1, 1, dc + 2, 1, 0, dc);
        expect_cmd("rr3", 1, 1, 2, 1, dc + 2, 1, 0, dc);
    endtask

    task automatic test_zero_rpt();
        int dc;
        mode1 = 1'b1; val1 = 4'd9; rpt1 = 8'd0; req1 = 1'b1;
        expect_cmd("zero_rpt", 1, 1, 9, 0, cyc + 1, 1, 0, dc);
    endtask

    task automatic test_clear();
        int dc;
        logic [2:0] g;
        mode1 = 1'b0; val1 = 4'd6; rpt1 = 8'd1;
        mode0 = 1'b0; val0 = 4'd1; rpt0 = 8'd2; req0 = 1'b1;
        expect_cmd("clr_run", 0, 0, 1, 2, cyc + 1, 1, 1, dc);
        @(negedge clk);
        total++;
        g = {cnt_clr_n, ack1, busy};
        if (g !== 3'b000 || cyc !== dc + 2) begin
            bad++;
            $display("FAIL clr_pulse: got %b at c%0d want 000 at c%0d", g, cyc, dc + 2);
        end
        @(negedge clk);
        total++;
        if (cnt_clr_n !== 1'b1 || cnt_obs !== 0) begin
            bad++;
            $display("FAIL clr_release: got n=%b cnt=%0d want n=1 cnt=0", cnt_clr_n, cnt_obs);
        end
        expect_cmd("clr_ack1", 1, 0, 6, 1, dc + 4, 1, 0, dc);
        // clear requested together with a request in IDLE wins
        rpt0 = 8'd0; req0 = 1'b1; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        total++;
        g = {cnt_clr_n, ack0, ack1};
        if (g !== 3'b000) begin
            bad++;
            $display("FAIL clr_priority: got %b want 000", g);
        end
        expect_cmd("clr_prio_ack", 0, 0, 1, 0, cyc + 2, 1, 0, dc);
    endtask

    task automatic test_reset_mid();
        int steps, dc;
        mode0 = 1'b0; val0 = 4'd7; rpt0 = 8'd5; req0 = 1'b1;
        @(negedge clk);
        total++;
        if (ack0 !== 1'b1) begin
            bad++;
            $display("FAIL mid_ack: got %b want 1", ack0);
        end
        req0 = 1'b0;
        steps = 0;
        for (int i = 0; i < 40 && steps < 2; i++) begin
            @(negedge clk);
            if (step_en) steps++;
        end
        total++;
        if (steps !== 2) begin
            bad++;
            $display("FAIL mid_steps: got %0d want 2", steps);
        end
        #2 reset = 1'b0;
        #1 check_reset_values("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mptr = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            total++;
            if ({done0, done1, busy, step_en} !== 4'b0000) begin
                bad++;
                $display("FAIL mid_quiet: got %b want 0000", {done0, done1, busy, step_en});
            end
        end
        mode0 = 1'b0; val0 = 4'd2; rpt0 = 8'd1; req0 = 1'b1;
        mode1 = 1'b1; val1 = 4'd4; rpt1 = 8'd1; req1 = 1'b1;
        expect_cmd("mid_first", 0, 0, 2, 1, cyc + 1, 1, 0, dc);
        expect_cmd("mid_second", 1, 1, 4, 1, dc + 2, 1, 0, dc);
    endtask

    task automatic test_decrement();
        int base, dc;
        base = cnt_obs;
        mode0 = 1'b1; val0 = 4'd5; rpt0 = 8'd1; req0 = 1'b1;
        expect_cmd("decrement", 0, 1, 5, 1, cyc + 1, 1, 0, dc);
        total++;
        if (2 + (cnt_obs - base) !== -3) begin
            bad++;
            $display("FAIL dec_count: got %0d want -3", 2 + (cnt_obs - base));
        end
    endtask

    task automatic test_random();
        int dc, w;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if (!req0 && ($urandom % 2 == 1)) begin
                mode0 = 1'($urandom); val0 = 4'($urandom); rpt0 = 8'($urandom % 4); req0 = 1'b1;
            end
            if (!req1 && ($urandom % 2 == 1)) begin
                mode1 = 1'($urandom); val1 = 4'($urandom); rpt1 = 8'($urandom % 4); req1 = 1'b1;
            end
            if (!req0 && !req1) begin
                mode0 = 1'($urandom); val0 = 4'($urandom); rpt0 = 8'($urandom % 4); req0 = 1'b1;
            end
            w = (req0 && req1) ? mptr : (req1 ? 1 : 0);
            mptr = 1 - w;
            if (w == 0)
                expect_cmd("rand", 0, int'(mode0), int'(val0), int'(rpt0), cyc + 1, 1, 0, dc);
            else
                expect_cmd("rand", 1, int'(mode1), int'(val1), int'(rpt1), cyc + 1, 1, 0, dc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_rpt();
        test_clear();
        test_reset_mid();
        test_decrement();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
